// File: rtl/imem_ctrl.sv
// imem_ctrl: shares one instruction SRAM between fetch and data-side reads,
// buffering fetch lines in a credit-protected, flushable response queue.
module imem_ctrl #(
  parameter int XLEN      = 32,
  parameter int IFETCHW   = 128,
  parameter int MEM_AW    = 12,
  parameter int RDQ_DEPTH = 4
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               im_addr_val,
  output logic               im_addr_rdy,
  input  logic [XLEN-1:0]    im_addr,
  input  logic               im_flush_val,
  output logic               im_rdata_val,
  input  logic               im_rdata_rdy,
  output logic [IFETCHW-1:0] im_rdata,
  input  logic               dm_req_val,
  output logic               dm_req_rdy,
  input  logic [XLEN-1:0]    dm_addr,
  output logic               dm_rsp_val,
  output logic [IFETCHW-1:0] dm_rsp_rdata,
  output logic               mem_en,
  output logic [MEM_AW-1:0]  mem_addr,
  input  logic [IFETCHW-1:0] mem_rdata
);
  localparam int QAW = $clog2(RDQ_DEPTH);
  localparam int CW = QAW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(RDQ_DEPTH);

  typedef enum logic [1:0] {SRC_NONE, SRC_IF, SRC_DM} src_e;

  src_e               src_q, src_d;
  logic               last_dm_q, last_dm_d;
  logic [CW-1:0]      q_cnt_q, q_cnt_d;
  logic [QAW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [IFETCHW-1:0] q_mem [RDQ_DEPTH];
  logic               if_inflight, if_ok, gnt_if, gnt_dm, push, pop;
  logic               unused_addr;

  // A read issued last cycle still owns a queue slot until it lands, so it
  // counts against credit; a same-cycle pop does not free one.
  assign if_inflight  = src_q == SRC_IF;
  assign if_ok        = im_flush_val | ((q_cnt_q + CW'(if_inflight)) < DEPTH);
  assign gnt_if       = im_addr_val & if_ok & (!dm_req_val | last_dm_q);
  assign gnt_dm       = dm_req_val & !gnt_if;
  assign im_addr_rdy  = gnt_if;
  assign dm_req_rdy   = gnt_dm;
  assign mem_en       = gnt_if | gnt_dm;
  assign mem_addr     = gnt_if ? im_addr[MEM_AW+3:4] : gnt_dm ? dm_addr[MEM_AW+3:4] : '0;
  assign dm_rsp_val   = src_q == SRC_DM;
  assign dm_rsp_rdata = mem_rdata;
  // Data landing during a flush belongs to the discarded stream.
  assign push         = if_inflight & !im_flush_val;
  assign im_rdata_val = (q_cnt_q != '0) & !im_flush_val;
  assign pop          = im_rdata_val & im_rdata_rdy;
  assign im_rdata     = q_mem[rd_ptr_q];
  assign unused_addr  = ^{im_addr[XLEN-1:MEM_AW+4], im_addr[3:0], dm_addr[XLEN-1:MEM_AW+4], dm_addr[3:0]};

  always_comb begin
    src_d     = gnt_if ? SRC_IF : gnt_dm ? SRC_DM : SRC_NONE;
    last_dm_d = gnt_dm | (last_dm_q & !gnt_if);
    rd_ptr_d  = im_flush_val ? '0 : rd_ptr_q + QAW'(pop);
    wr_ptr_d  = im_flush_val ? '0 : wr_ptr_q + QAW'(push);
    q_cnt_d   = im_flush_val ? '0 : q_cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      src_q     <= SRC_NONE;
      last_dm_q <= 1'b1;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      q_cnt_q   <= '0;
    end else begin
      src_q     <= src_d;
      last_dm_q <= last_dm_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      q_cnt_q   <= q_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr_q] <= mem_rdata;
  end

  assert property (@(posedge clk) disable iff (!arst_n) !(push && q_cnt_q == DEPTH));
endmodule

// File: tb/tb_imem_ctrl.sv
// tb_imem_ctrl: directed checks of imem_ctrl arbitration, fetch queue,
// flush and reset behaviour against a one-cycle-latency SRAM model.
module tb_imem_ctrl;
  localparam int XLEN = 32, IFETCHW = 128, MEM_AW = 12, RDQ_DEPTH = 4;

  logic               clk = 1'b0, arst_n = 1'b1;
  logic               im_addr_val = 0, im_addr_rdy, im_flush_val = 0, im_rdata_val, im_rdata_rdy = 0;
  logic [XLEN-1:0]    im_addr = '0, dm_addr = '0;
  logic [IFETCHW-1:0] im_rdata, dm_rsp_rdata, mem_rdata = '0;
  logic               dm_req_val = 0, dm_req_rdy, dm_rsp_val, mem_en;
  logic [MEM_AW-1:0]  mem_addr;
  int                 n_tests = 0, n_fail = 0;

  imem_ctrl #(.XLEN(XLEN), .IFETCHW(IFETCHW), .MEM_AW(MEM_AW), .RDQ_DEPTH(RDQ_DEPTH)) dut (
    .clk(clk), .arst_n(arst_n),
    .im_addr_val(im_addr_val), .im_addr_rdy(im_addr_rdy), .im_addr(im_addr),
    .im_flush_val(im_flush_val), .im_rdata_val(im_rdata_val), .im_rdata_rdy(im_rdata_rdy),
    .im_rdata(im_rdata), .dm_req_val(dm_req_val), .dm_req_rdy(dm_req_rdy), .dm_addr(dm_addr),
    .dm_rsp_val(dm_rsp_val), .dm_rsp_rdata(dm_rsp_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [IFETCHW-1:0] line_data(input logic [MEM_AW-1:0] l);
    return {4{20'hC0DE5, l}};
  endfunction

  always @(posedge clk) mem_rdata <= mem_en ? line_data(mem_addr) : '0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 arst_n = 1'b0;
    #1;
    n_tests++; if ({im_rdata_val, dm_rsp_val, mem_en} !== 3'b000) begin n_fail++; $display("FAIL reset_outputs: got %b want 000", {im_rdata_val, dm_rsp_val, mem_en}); end
    n_tests++; if (dut.q_cnt_q !== '0) begin n_fail++; $display("FAIL reset_q_cnt: got %0d want 0", dut.q_cnt_q); end
    tick(); tick();
    arst_n = 1'b1;
    tick();
    @(negedge clk);
    n_tests++; if ({im_rdata_val, dm_rsp_val, mem_en} !== 3'b000) begin n_fail++; $display("FAIL post_reset_outputs: got %b want 000", {im_rdata_val, dm_rsp_val, mem_en}); end
    tick();
  endtask

  task automatic test_single_fetch();
    im_addr_val = 1; im_addr = 32'h0000_0040; im_rdata_rdy = 1;
    @(negedge clk);
    n_tests++; if ({im_addr_rdy, mem_en} !== 2'b11) begin n_fail++; $display("FAIL single_grant: got %b want 11", {im_addr_rdy, mem_en}); end
    n_tests++; if (mem_addr !== 12'd4) begin n_fail++; $display("FAIL single_mem_addr: got %0d want 4", mem_addr); end
    tick(); im_addr_val = 0; im_addr = '0;
    @(negedge clk);
    n_tests++; if (im_rdata_val !== 1'b0) begin n_fail++; $display("FAIL single_t1_val: got %b want 0", im_rdata_val); end
    tick(); @(negedge clk);
    n_tests++; if (im_rdata_val !== 1'b1) begin n_fail++; $display("FAIL single_t2_val: got %b want 1", im_rdata_val); end
    n_tests++; if (im_rdata !== line_data(12'd4)) begin n_fail++; $display("FAIL single_data: got %h want %h", im_rdata, line_data(12'd4)); end
    tick(); @(negedge clk);
    n_tests++; if (im_rdata_val !== 1'b0) begin n_fail++; $display("FAIL single_one_beat: got %b want 0", im_rdata_val); end
    tick();
  endtask

  task automatic test_back_to_back();
    int idx = 0, exp = 0, cyc = 0;
    im_rdata_rdy = 0;
    repeat (8) begin
      im_addr_val = idx < 10; im_addr = 32'(idx) << 4;
      @(negedge clk);
      if (im_addr_rdy) idx++;
      tick();
    end
    im_addr_val = 1; im_addr = 32'(idx) << 4;
    @(negedge clk);
    n_tests++; if (idx !== 4) begin n_fail++; $display("FAIL bp_grants: got %0d want 4", idx); end
    n_tests++; if (im_addr_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_stalled: got %b want 0", im_addr_rdy); end
    n_tests++; if (im_rdata_val !== 1'b1) begin n_fail++; $display("FAIL bp_full_val: got %b want 1", im_rdata_val); end
    tick();
    im_rdata_rdy = 1;
    while (exp < 10 && cyc < 60) begin
      im_addr_val = idx < 10; im_addr = 32'(idx) << 4;
      @(negedge clk);
      if (im_addr_rdy) idx++;
      if (im_rdata_val) begin
        n_tests++; if (im_rdata !== line_data(12'(exp))) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", exp, im_rdata, line_data(12'(exp))); end
        exp++;
      end
      cyc++;
      tick();
    end
    n_tests++; if (exp !== 10) begin n_fail++; $display("FAIL bp_delivered: got %0d want 10", exp); end
    im_addr_val = 0;
    repeat (3) begin
      @(negedge clk);
      n_tests++; if (im_rdata_val !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got %b want 0", im_rdata_val); end
      tick();
    end
  endtask

  task automatic test_contention();
    int exp_seq [6] = '{1, 10, 2, 11, 3, 12};
    int fi = 1, di = 10;
    logic prev_dm = 0;
    dm_req_val = 1; dm_addr = 32'h50;
    @(negedge clk);
    n_tests++; if ({dm_req_rdy, mem_addr} !== {1'b1, 12'd5}) begin n_fail++; $display("FAIL dm_grant: got %b/%0d want 1/5", dm_req_rdy, mem_addr); end
    tick(); dm_req_val = 0;
    @(negedge clk);
    n_tests++; if (dm_rsp_val !== 1'b1 || dm_rsp_rdata !== line_data(12'd5)) begin n_fail++; $display("FAIL dm_rsp: got %b/%h want 1/%h", dm_rsp_val, dm_rsp_rdata, line_data(12'd5)); end
    tick();
    im_rdata_rdy = 1;
    for (int k = 0; k < 7; k++) begin
      im_addr_val = k < 6; dm_req_val = k < 6;
      im_addr = 32'(fi) << 4; dm_addr = 32'(di) << 4;
      @(negedge clk);
      if (prev_dm) begin
        n_tests++; if (dm_rsp_val !== 1'b1 || dm_rsp_rdata !== line_data(12'(exp_seq[k-1]))) begin n_fail++; $display("FAIL cont_dm_rsp[%0d]: got %b/%h want 1/%h", k, dm_rsp_val, dm_rsp_rdata, line_data(12'(exp_seq[k-1]))); end
      end
      if (k < 6) begin
        n_tests++; if (mem_en !== 1'b1 || mem_addr !== 12'(exp_seq[k])) begin n_fail++; $display("FAIL cont_seq[%0d]: got %b/%0d want 1/%0d", k, mem_en, mem_addr, exp_seq[k]); end
      end
      prev_dm = (k < 6) && (k % 2 == 1);
      if (im_addr_rdy) fi++;
      if (dm_req_rdy) di++;
      tick();
    end
    repeat (2) tick();
  endtask

  task automatic test_flush();
    im_rdata_rdy = 0;
    for (int k = 0; k < 4; k++) begin
      im_addr_val = 1; im_addr = 32'(20 + k) << 4;
      @(negedge clk);
      n_tests++; if (im_addr_rdy !== 1'b1) begin n_fail++; $display("FAIL flush_fill[%0d]: got %b want 1", k, im_addr_rdy); end
      if (k == 3) begin
        n_tests++; if (im_rdata_val !== 1'b1) begin n_fail++; $display("FAIL flush_prefill_val: got %b want 1", im_rdata_val); end
      end
      tick();
    end
    im_flush_val = 1; im_addr = 32'h100;
    @(negedge clk);
    n_tests++; if (im_rdata_val !== 1'b0) begin n_fail++; $display("FAIL flush_val_masked: got %b want 0", im_rdata_val); end
    n_tests++; if ({im_addr_rdy, mem_addr} !== {1'b1, 12'd16}) begin n_fail++; $display("FAIL flush_grant: got %b/%0d want 1/16", im_addr_rdy, mem_addr); end
    tick(); im_flush_val = 0; im_addr_val = 0;
    @(negedge clk);
    n_tests++; if (im_rdata_val !== 1'b0) begin n_fail++; $display("FAIL flush_cancelled: got %b want 0", im_rdata_val); end
    tick(); im_rdata_rdy = 1;
    @(negedge clk);
    n_tests++; if (im_rdata_val !== 1'b1 || im_rdata !== line_data(12'd16)) begin n_fail++; $display("FAIL flush_next: got %b/%h want 1/%h", im_rdata_val, im_rdata, line_data(12'd16)); end
    tick(); @(negedge clk);
    n_tests++; if (im_rdata_val !== 1'b0) begin n_fail++; $display("FAIL flush_only_one: got %b want 0", im_rdata_val); end
    tick();
  endtask

  task automatic test_dm_stall();
    im_rdata_rdy = 0; im_addr_val = 1; im_addr = '0;
    repeat (6) tick();
    dm_req_val = 1;
    for (int k = 0; k < 6; k++) begin
      dm_addr = 32'(30 + k) << 4;
      @(negedge clk);
      n_tests++; if ({dm_req_rdy, im_addr_rdy} !== 2'b10) begin n_fail++; $display("FAIL stall_grant[%0d]: got %b want 10", k, {dm_req_rdy, im_addr_rdy}); end
      if (k > 0) begin
        n_tests++; if (dm_rsp_val !== 1'b1 || dm_rsp_rdata !== line_data(12'(29 + k))) begin n_fail++; $display("FAIL stall_rsp[%0d]: got %b/%h want 1/%h", k, dm_rsp_val, dm_rsp_rdata, line_data(12'(29 + k))); end
      end
      tick();
    end
    dm_req_val = 0; im_addr_val = 0;
    @(negedge clk);
    n_tests++; if (dm_rsp_val !== 1'b1 || dm_rsp_rdata !== line_data(12'd35)) begin n_fail++; $display("FAIL stall_last_rsp: got %b/%h want 1/%h", dm_rsp_val, dm_rsp_rdata, line_data(12'd35)); end
    n_tests++; if (im_rdata_val !== 1'b1) begin n_fail++; $display("FAIL stall_still_full: got %b want 1", im_rdata_val); end
    tick();
  endtask

  task automatic test_async_reset();
    dm_req_val = 1; dm_addr = 32'h280;
    tick(); dm_req_val = 0;
    #1 arst_n = 1'b0;
    #1;
    n_tests++; if ({im_rdata_val, dm_rsp_val, mem_en} !== 3'b000) begin n_fail++; $display("FAIL areset_outputs: got %b want 000", {im_rdata_val, dm_rsp_val, mem_en}); end
    n_tests++; if (dut.q_cnt_q !== '0) begin n_fail++; $display("FAIL areset_q_cnt: got %0d want 0", dut.q_cnt_q); end
    tick(); tick();
    arst_n = 1'b1; im_rdata_rdy = 1;
    repeat (4) begin
      @(negedge clk);
      n_tests++; if ({im_rdata_val, dm_rsp_val} !== 2'b00) begin n_fail++; $display("FAIL areset_quiet: got %b want 00", {im_rdata_val, dm_rsp_val}); end
      tick();
    end
    im_addr_val = 1; dm_req_val = 1; im_addr = 32'h70; dm_addr = 32'h80;
    @(negedge clk);
    n_tests++; if ({im_addr_rdy, dm_req_rdy} !== 2'b10) begin n_fail++; $display("FAIL areset_if_first: got %b want 10", {im_addr_rdy, dm_req_rdy}); end
    tick(); im_addr_val = 0;
    @(negedge clk);
    n_tests++; if (dm_req_rdy !== 1'b1) begin n_fail++; $display("FAIL areset_dm_next: got %b want 1", dm_req_rdy); end
    tick(); dm_req_val = 0;
    @(negedge clk);
    n_tests++; if (im_rdata_val !== 1'b1 || im_rdata !== line_data(12'd7)) begin n_fail++; $display("FAIL areset_fresh_if: got %b/%h want 1/%h", im_rdata_val, im_rdata, line_data(12'd7)); end
    n_tests++; if (dm_rsp_val !== 1'b1 || dm_rsp_rdata !== line_data(12'd8)) begin n_fail++; $display("FAIL areset_fresh_dm: got %b/%h want 1/%h", dm_rsp_val, dm_rsp_rdata, line_data(12'd8)); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_contention();
    test_flush();
    test_dm_stall();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
